// File: rtl/mmio_bridge_arb.sv
// mmio_bridge_arb: registered MMIO bridge from the CPU data port to up to
// NUM_SLAVES peripherals. It decodes the address range, rejects partial writes to
// word-only slaves, waits for a per-slave ready, and aborts with an error on timeout.
// Every access completes with exactly one cpu_ack_o pulse.
// Optional build macro: MMIO_BRIDGE_PERF_EN adds saturating per-slave success
// counters and an error counter, exposed as perf_cnt_o and perf_err_o.
module mmio_bridge_arb #(
    parameter int                        NUM_SLAVES     = 5,
    parameter logic [32*NUM_SLAVES-1:0]  BASE_ADDRS     = {32'h7F70, 32'h7F50, 32'h7F30, 32'h7F10, 32'h0000},
    parameter logic [32*NUM_SLAVES-1:0]  LIMIT_ADDRS    = {32'h7F7F, 32'h7F6B, 32'h7F4F, 32'h7F2B, 32'h2FFF},
    parameter logic [NUM_SLAVES-1:0]     WORD_ONLY_MASK = 5'b00110,
    parameter int                        TIMEOUT_CYCLES = 255
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       cpu_req_i,
    input  logic [31:0]                cpu_addr_i,
    input  logic [3:0]                 cpu_byteEn_i,
    input  logic [31:0]                cpu_wdata_i,
    output logic                       cpu_ack_o,
    output logic                       cpu_err_o,
    output logic [31:0]                cpu_rdata_o,
    output logic                       cpu_busy_o,
    output logic [NUM_SLAVES-1:0]      s_sel_o,
    output logic [31:0]                s_addr_o,
    output logic [3:0]                 s_byteEn_o,
    output logic [31:0]                s_wdata_o,
    input  logic [32*NUM_SLAVES-1:0]   s_rdata_i,
    input  logic [NUM_SLAVES-1:0]      s_ready_i
`ifdef MMIO_BRIDGE_PERF_EN
    ,
    output logic [32*NUM_SLAVES-1:0]   perf_cnt_o,
    output logic [31:0]                perf_err_o
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    state_t                  state_q;
    logic [NUM_SLAVES-1:0]   sel_q;
    logic [IDX_W-1:0]        idx_q;
    logic [31:0]             addr_q;
    logic [3:0]              be_q;
    logic [31:0]             wdata_q;
    logic                    ack_q;
    logic                    err_q;
    logic [31:0]             rdata_q;
    logic [CNT_W-1:0]        cnt_q;

    logic [NUM_SLAVES-1:0]   hit;
    logic [NUM_SLAVES-1:0]   sel_d;
    logic                    hit_any;
    logic [IDX_W-1:0]        hit_idx;
    logic                    word_bad;
    logic                    slave_done;
    logic [31:0]             rdata_arr [NUM_SLAVES];

    // Per-slave range compare, read-data unpacking and one-hot select candidate.
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
            assign hit[gi] = (cpu_addr_i >= BASE_ADDRS[32*gi +: 32]) &&
                             (cpu_addr_i <= LIMIT_ADDRS[32*gi +: 32]);
            assign rdata_arr[gi] = s_rdata_i[32*gi +: 32];
            assign sel_d[gi] = hit_any && (hit_idx == IDX_W'(gi));
        end
    endgenerate

    // Priority encode the hit vector; scanning downward leaves the lowest index in place.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // A word-only slave accepts reads and full-word writes only.
    assign word_bad = WORD_ONLY_MASK[hit_idx] && (cpu_byteEn_i != 4'b0000) &&
                      (cpu_byteEn_i != 4'b1111);

    // The selected slave alone can complete the access; other ready lines are ignored.
    assign slave_done = |(sel_q & s_ready_i);

    // Bridge FSM: IDLE latches and decodes, ACCESS waits for ready or timeout,
    // and RESP presents the one-cycle ack.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req_i) begin
                        addr_q  <= cpu_addr_i;
                        be_q    <= cpu_byteEn_i;
                        wdata_q <= cpu_wdata_i;
                        cnt_q   <= '0;
                        if (!hit_any || word_bad) begin
                            // Rejected without touching any slave.
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            ack_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end else begin
                            idx_q   <= hit_idx;
                            sel_q   <= sel_d;
                            state_q <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (slave_done) begin
                        rdata_q <= (be_q == 4'b0000) ? rdata_arr[idx_q] : 32'h0;
                        err_q   <= 1'b0;
                        ack_q   <= 1'b1;
                        sel_q   <= '0;
                        state_q <= ST_RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        ack_q   <= 1'b1;
                        sel_q   <= '0;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_ack_o   = ack_q;
    assign cpu_err_o   = err_q;
    assign cpu_rdata_o = rdata_q;
    assign cpu_busy_o  = (state_q != ST_IDLE) || cpu_req_i;
    assign s_sel_o     = sel_q;
    assign s_addr_o    = addr_q;
    assign s_byteEn_o  = be_q;
    assign s_wdata_o   = wdata_q;

`ifdef MMIO_BRIDGE_PERF_EN
    logic [31:0] perf_cnt_q [NUM_SLAVES];
    logic [31:0] perf_err_q;

    // Count acks: successes per slave, errors globally; every counter saturates.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                perf_cnt_q[i] <= '0;
            end
            perf_err_q <= '0;
        end else if (ack_q) begin
            if (err_q) begin
                if (perf_err_q != 32'hFFFF_FFFF) begin
                    perf_err_q <= perf_err_q + 32'd1;
                end
            end else if (perf_cnt_q[idx_q] != 32'hFFFF_FFFF) begin
                perf_cnt_q[idx_q] <= perf_cnt_q[idx_q] + 32'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_perf
            assign perf_cnt_o[32*gi +: 32] = perf_cnt_q[gi];
        end
    endgenerate
    assign perf_err_o = perf_err_q;
`endif

endmodule

// File: tb/tb_mmio_bridge_arb.sv
// Directed testbench for mmio_bridge_arb. Expected responses go into a queue
// when an access is issued, and a monitor compares them on every cpu_ack.
module tb_mmio_bridge_arb;

    localparam int NS = 5;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req;
    logic [31:0]       cpu_addr;
    logic [3:0]        cpu_byteEn;
    logic [31:0]       cpu_wdata;
    logic              cpu_ack;
    logic              cpu_err;
    logic [31:0]       cpu_rdata;
    logic              cpu_busy;
    logic [NS-1:0]     s_sel;
    logic [31:0]       s_addr;
    logic [3:0]        s_byteEn;
    logic [31:0]       s_wdata;
    logic [32*NS-1:0]  s_rdata;
    logic [NS-1:0]     s_ready;
`ifdef MMIO_BRIDGE_PERF_EN
    logic [32*NS-1:0]  perf_cnt;
    logic [31:0]       perf_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    mmio_bridge_arb #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .cpu_req_i    (cpu_req),
        .cpu_addr_i   (cpu_addr),
        .cpu_byteEn_i (cpu_byteEn),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_ack_o    (cpu_ack),
        .cpu_err_o    (cpu_err),
        .cpu_rdata_o  (cpu_rdata),
        .cpu_busy_o   (cpu_busy),
        .s_sel_o      (s_sel),
        .s_addr_o     (s_addr),
        .s_byteEn_o   (s_byteEn),
        .s_wdata_o    (s_wdata),
        .s_rdata_i    (s_rdata),
        .s_ready_i    (s_ready)
`ifdef MMIO_BRIDGE_PERF_EN
        ,
        .perf_cnt_o   (perf_cnt),
        .perf_err_o   (perf_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign s_rdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222,
                      32'h1111_1111, 32'hDEAD_BEEF};

    // Slave model: ready after wait_cfg[i] cycles of select, plus noise on idle lines.
    int            wait_cfg [NS];
    int            sel_cnt  [NS];
    int            sel_total[NS];
    logic [NS-1:0] noise;

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) sel_cnt[i] <= s_sel[i] ? sel_cnt[i] + 1 : 0;
    end

    always_comb begin
        s_ready = '0;
        for (int i = 0; i < NS; i++)
            s_ready[i] = (s_sel[i] && (sel_cnt[i] >= wait_cfg[i])) || noise[i];
    end

    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) if (s_sel[i]) sel_total[i] <= sel_total[i] + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard of expected {err, rdata} per ack.
    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin
        exp_t e;
        if (!rst && cpu_ack) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack with nothing expected (err=%0b rdata=%h)",
                         cpu_err, cpu_rdata);
            end else begin
                e = exp_q.pop_front();
                chk("cpu_err", {31'b0, cpu_err}, {31'b0, e.err});
                chk("cpu_rdata", cpu_rdata, e.rdata);
            end
        end
    end

    // Latched slave-side fields must stay stable while a slave is selected.
    logic        lat_chk = 1'b0;
    logic [31:0] lat_addr, lat_wd;
    logic [3:0]  lat_be;

    always @(negedge clk) begin
        if (lat_chk && (s_sel != '0)) begin
            chk("s_addr_stable", s_addr, lat_addr);
            chk("s_byteEn_stable", {28'b0, s_byteEn}, {28'b0, lat_be});
            chk("s_wdata_stable", s_wdata, lat_wd);
        end
    end

    task automatic wait_ack(input string nm, output int at);
        bit got = 1'b0;
        at = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (cpu_ack) begin
                got = 1'b1;
                at  = cyc;
            end
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_ack_wait: got no ack within 40 cycles, required one ack", nm);
        end
    endtask

    task automatic do_access(input string nm, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                             input int exp_slave, input int exp_sel_cyc, input int exp_lat);
        int start;
        int at;
        int tot;
        int base [NS];
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) base[i] = sel_total[i];
        exp_q.push_back({exp_err, exp_rd});
        lat_addr = addr;
        lat_be   = be;
        lat_wd   = wd;
        lat_chk  = 1'b1;
        cpu_addr   = addr;
        cpu_byteEn = be;
        cpu_wdata  = wd;
        cpu_req    = 1'b1;
        start      = cyc;
        @(negedge clk);
        chk({nm, "_busy"}, {31'b0, cpu_busy}, 32'd1);
        @(posedge clk);
        #1;
        // Inputs change while busy; the bridge must keep using the latched copy.
        cpu_addr   = ~addr;
        cpu_byteEn = ~be;
        cpu_wdata  = ~wd;
        if (cpu_ack) at = cyc;
        else wait_ack(nm, at);
        cpu_req = 1'b0;
        lat_chk = 1'b0;
        chk({nm, "_latency"}, 32'(at - start), 32'(exp_lat));
        tot = 0;
        for (int i = 0; i < NS; i++) tot += sel_total[i] - base[i];
        chk({nm, "_sel_cycles"}, 32'(tot), 32'(exp_sel_cyc));
        if (exp_slave >= 0)
            chk({nm, "_sel_slave"}, 32'(sel_total[exp_slave] - base[exp_slave]), 32'(exp_sel_cyc));
        $display("access %s addr=%h be=%b err=%0b rdata=%h lat=%0d", nm, addr, be,
                 cpu_err, cpu_rdata, at - start);
    endtask

    initial begin
        int a0, a1, a2;
        rst        = 1'b1;
        cpu_req    = 1'b0;
        cpu_addr   = '0;
        cpu_byteEn = '0;
        cpu_wdata  = '0;
        noise      = '0;
        for (int i = 0; i < NS; i++) begin
            wait_cfg[i]  = 0;
            sel_total[i] = 0;
        end
        #1;
        chk("rst_s_sel", {27'b0, s_sel}, 32'd0);
        chk("rst_ack", {31'b0, cpu_ack}, 32'd0);
        chk("rst_busy", {31'b0, cpu_busy}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Zero-wait read of DM; ready noise on all other slaves must be ignored.
        noise = 5'b11110;
        do_access("dm_read", 32'h0000_0100, 4'b0000, 32'h0, 1'b0, 32'hDEAD_BEEF, 0, 1, 2);
        // Full-word write to slave 1 with 3 wait states; write returns rdata 0.
        noise = 5'b00001;
        wait_cfg[1] = 3;
        do_access("ws_write", 32'h0000_7F10, 4'b1111, 32'h1234_5678, 1'b0, 32'h0, 1, 4, 5);
        // Decode miss and word-only violation: error ack in cycle 1, no select.
        noise = 5'b00000;
        do_access("decode_err", 32'h0000_5000, 4'b0000, 32'h0, 1'b1, 32'h0, -1, 0, 1);
        do_access("word_only_err", 32'h0000_7F20, 4'b0011, 32'hAAAA_5555, 1'b1, 32'h0, -1, 0, 1);
        // Timeout: slave 3 never ready, others noisy.
        noise = 5'b10111;
        wait_cfg[3] = 1000;
        do_access("timeout", 32'h0000_7F54, 4'b0000, 32'h0, 1'b1, 32'h0, 3, 4, 5);
        noise = 5'b00000;

        // Back-to-back: req held high across two zero-wait reads.
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        cpu_addr   = 32'h0000_0200;
        cpu_byteEn = 4'b0000;
        cpu_req    = 1'b1;
        a0         = cyc;
        wait_ack("b2b_first", a1);
        wait_ack("b2b_second", a2);
        cpu_req = 1'b0;
        chk("b2b_first_latency", 32'(a1 - a0), 32'd2);
        chk("b2b_spacing", 32'(a2 - a1), 32'd3);
        $display("access b2b acks at cycles %0d and %0d", a1, a2);

        // Asynchronous reset in the middle of a stalled access.
        @(posedge clk);
        #1;
        cpu_addr = 32'h0000_7F54;
        cpu_req  = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        cpu_req = 1'b0;
        rst     = 1'b1;
        #1;
        chk("arst_s_sel", {27'b0, s_sel}, 32'd0);
        chk("arst_s_addr", s_addr, 32'd0);
        chk("arst_s_byteEn", {28'b0, s_byteEn}, 32'd0);
        chk("arst_ack", {31'b0, cpu_ack}, 32'd0);
        chk("arst_err", {31'b0, cpu_err}, 32'd0);
        chk("arst_rdata", cpu_rdata, 32'd0);
        chk("arst_busy", {31'b0, cpu_busy}, 32'd0);
        #3;
        rst = 1'b0;
        $display("access async reset during ACCESS");

        // Range boundaries of DM, three reads and one miss just past the limit.
        do_access("post_rst_read", 32'h0000_0000, 4'b0000, 32'h0, 1'b0, 32'hDEAD_BEEF, 0, 1, 2);
        do_access("dm_limit_read", 32'h0000_2FFC, 4'b0000, 32'h0, 1'b0, 32'hDEAD_BEEF, 0, 1, 2);
        do_access("dm_read_3", 32'h0000_0100, 4'b0000, 32'h0, 1'b0, 32'hDEAD_BEEF, 0, 1, 2);
        do_access("past_limit_err", 32'h0000_3000, 4'b0000, 32'h0, 1'b1, 32'h0, -1, 0, 1);

        repeat (3) @(posedge clk);
        #1;
`ifdef MMIO_BRIDGE_PERF_EN
        chk("perf_cnt_dm", perf_cnt[31:0], 32'd3);
        chk("perf_err", perf_err, 32'd1);
`endif
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish within 100000 time units");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/mmio_bridge_arb.md
Name: mmio_bridge_arb

Overview:
- Parametrised, registered MMIO bridge between the CPU data port and up to NUM_SLAVES peripherals.
- Successor to the combinational address decoder. Adds:
  - per-slave variable-latency ready handshake;
  - a request/ack protocol toward the CPU, used to stall the M stage;
  - decode-error and timeout reporting;
  - word-only enforcement for slaves that cannot take partial writes.
- Sits between the CPU M stage and the DM/Timer/UART/IO slaves.

Parameters:
- NUM_SLAVES, 5, number of slave channels (1..8).
- BASE_ADDRS, {32'h7F70,32'h7F50,32'h7F30,32'h7F10,32'h0000} packed 32*NUM_SLAVES, inclusive base per slave; slot i at bits [32i+31:32i].
- LIMIT_ADDRS, {32'h7F7F,32'h7F6B,32'h7F4F,32'h7F2B,32'h2FFF} packed, inclusive limit per slave.
- WORD_ONLY_MASK, 5'b00110, bit i=1: slave i accepts only full-word writes (byteEn 4'b1111).
- TIMEOUT_CYCLES, 255, max cycles spent waiting in ACCESS; must be ≥1, counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cpu_req  input  1  access request, held until cpu_ack
- cpu_addr  input  32  byte address
- cpu_byteEn  input  4  write byte enables; 4'b0000 = read
- cpu_wdata  input  32  write data
- cpu_ack  output  1  one-cycle completion pulse
- cpu_err  output  1  valid with cpu_ack; 1 = decode, word-only or timeout error
- cpu_rdata  output  32  read data, valid with cpu_ack
- cpu_busy  output  1  high in ACCESS/RESP; used as pipeline stall
- s_sel  output  NUM_SLAVES  one-hot slave select, registered
- s_addr  output  32  latched address
- s_byteEn  output  4  latched byte enables
- s_wdata  output  32  latched write data
- s_rdata  input  32*NUM_SLAVES  packed slave read data
- s_ready  input  NUM_SLAVES  slave i completes the access in the cycle s_sel[i]&&s_ready[i]

Behaviour:
- Reset: state=IDLE, s_sel=0, s_addr=0, s_byteEn=0, s_wdata=0, cpu_ack=0, cpu_err=0, cpu_rdata=0, cpu_busy=0, timeout counter=0.
- Async reset mid-access aborts immediately. No ack is issued. The slave sees s_sel drop and must not treat this as completion.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, when cpu_req=1:
  - Latch cpu_addr, cpu_byteEn and cpu_wdata.
  - Decode: hit_i = BASE_i ≤ addr ≤ LIMIT_i. The lowest index wins on overlap.
  - No hit, or a word-only slave with byteEn∉{0000,1111}: go to RESP with err=1. s_sel stays 0 and no slave is touched.
  - Otherwise: s_sel=onehot(idx), counter=0, go to ACCESS.
- ACCESS:
  - If s_ready[idx]: capture s_rdata[idx] (zero for writes), clear s_sel, go to RESP with err=0.
  - Otherwise increment the counter. At counter==TIMEOUT_CYCLES-1 without ready: clear s_sel, go to RESP with err=1, rdata=0.
- RESP:
  - cpu_ack=1 for exactly one cycle, with cpu_err/cpu_rdata valid; then go to IDLE.
  - cpu_rdata and cpu_err hold their values until the next ack.
- Minimum latency: req sampled at edge 0, s_sel high cycle 1, ready in cycle 1, cpu_ack in cycle 2 (3-cycle access). The error path without slave access acks in cycle 1.
- cpu_req already high in the cycle after ack starts a new access; IDLE is visited for ≥1 cycle.
- s_ready for a non-selected slave is ignored. s_ready in IDLE/RESP is ignored.
- Changes to cpu_req/addr while busy are ignored; the latched copy is used.
- cpu_busy = (state!=IDLE) || (state==IDLE && cpu_req).

Optional Feature:
- Macro: MMIO_BRIDGE_PERF_EN.
- Defined:
  - Per-slave 32-bit saturating counters count completed non-error accesses.
  - One extra 32-bit counter counts errors.
  - Read-only ports: perf_cnt (32*NUM_SLAVES), perf_err (32).
  - All counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Read DM (idx 0): req addr 32'h0000_0100, byteEn 0, s_ready[0]=1 immediately, s_rdata[0]=32'hDEAD_BEEF -> s_sel=5'b00001 in cycle 1, cpu_ack in cycle 2 with rdata 32'hDEAD_BEEF, err=0.
- Wait states: write 32'h1234_5678 to 32'h7F10, byteEn 4'b1111, s_ready[1] asserted 3 cycles after s_sel -> s_sel held 4 cycles, s_wdata/s_byteEn stable, single ack with err=0.
- Decode/word-only errors:
  - Access to 32'h0000_5000 -> ack in cycle 1, err=1, s_sel never set.
  - byteEn 4'b0011 to 32'h7F20 (slave 1) -> err=1, no select.
- Timeout: TIMEOUT_CYCLES=4, s_ready[3] never asserted -> s_sel[3] high exactly 4 cycles, then ack with err=1, rdata=0.
- Back-to-back and reset: two requests with req held high -> acks exactly 3 cycles apart at zero wait. Assert reset during ACCESS -> all outputs 0 asynchronously, no ack, next request proceeds normally.
- With MMIO_BRIDGE_PERF_EN: 3 DM reads + 1 decode error -> perf_cnt slot 0 = 3, perf_err = 1.
